// File: rtl/bcol_if.sv
// Handshake bundle between the weight/activation producer and the bit-column scheduler.
// Master drives groups in and accepts beats; slave is the scheduler side.
interface bcol_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] weights;
  logic [63:0] in_activations;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  weight_column0;
  logic [7:0]  weight_column1;
  logic [7:0]  weight_column2;
  logic [7:0]  weight_column3;
  logic [7:0]  weight_sign;
  logic [11:0] shift_offset;
  logic [63:0] activations;
  logic        out_first;
  logic        out_last;

  modport master (
    output in_valid, weights, in_activations, out_ready,
    input  in_ready, out_valid, weight_column0, weight_column1, weight_column2,
           weight_column3, weight_sign, shift_offset, activations, out_first, out_last
  );

  modport slave (
    input  in_valid, weights, in_activations, out_ready,
    output in_ready, out_valid, weight_column0, weight_column1, weight_column2,
           weight_column3, weight_sign, shift_offset, activations, out_first, out_last
  );
endinterface

// File: rtl/bcol_scheduler.sv
// Converts eight int8 weights to sign-magnitude bit-columns, drops all-zero columns,
// and issues the survivors four per beat to the bit-serial dot-product stage.
module bcol_scheduler (
  input logic  clk,
  input logic  rst_n,
  bcol_if.slave bus
);
  localparam int unsigned NW = 8;  // weights per group
  localparam int unsigned NK = 7;  // magnitude bit-columns
  localparam int unsigned NS = 4;  // column slots per beat
  localparam int unsigned KW = 3;  // bit-position field width

  typedef enum logic [1:0] {EMPTY, BEAT0, BEAT1} state_t;

  state_t state_q, state_d;

  logic [NW-1:0][NK-1:0] mag;
  logic [NK-1:0][NW-1:0] col;
  logic [NK-1:0]         mask;
  logic [NS-1:0][NW-1:0] b0_col, b1_col;
  logic [NS-1:0][KW-1:0] b0_off, b1_off;
  logic [3:0]            pop;
  logic                  two_beats;

  logic [NS-1:0][NW-1:0] col_q, pend_col_q;
  logic [NS-1:0][KW-1:0] off_q, pend_off_q;
  logic [NW-1:0]         sign_q;
  logic [63:0]           act_q;
  logic                  valid_q, first_q, last_q;

  logic in_ready, accept, load_pend, drain;

  // Sign-magnitude conversion; -128 saturates to 127 so it still fits 7 bits.
  always_comb begin
    mag  = '0;
    col  = '0;
    mask = '0;
    for (int unsigned i = 0; i < NW; i++) begin
      if (!bus.weights[8*i+7])
        mag[i] = bus.weights[8*i +: 7];
      else if (bus.weights[8*i +: 7] == 7'd0)
        mag[i] = 7'h7F;
      else
        mag[i] = ~bus.weights[8*i +: 7] + 7'd1;
    end
    for (int unsigned k = 0; k < NK; k++)
      for (int unsigned i = 0; i < NW; i++)
        col[k][i] = mag[i][k];
    for (int unsigned k = 0; k < NK; k++)
      mask[k] = |col[k];
  end

  // Compact non-zero columns in ascending bit order: first four to beat 0, rest to beat 1.
  always_comb begin
    b0_col = '0;
    b0_off = '0;
    b1_col = '0;
    b1_off = '0;
    pop    = '0;
    for (int unsigned k = 0; k < NK; k++) begin
      if (mask[k]) begin
        if (pop < 4'd4) begin
          b0_col[pop[1:0]] = col[k];
          b0_off[pop[1:0]] = 3'(k);
        end else begin
          b1_col[pop[1:0]] = col[k];
          b1_off[pop[1:0]] = 3'(k);
        end
        pop = pop + 4'd1;
      end
    end
    two_beats = (pop > 4'd4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (bus.in_valid) state_d = BEAT0;
      BEAT0: begin
        if (bus.out_ready) begin
          if (!last_q)           state_d = BEAT1;
          else if (bus.in_valid) state_d = BEAT0;
          else                   state_d = EMPTY;
        end
      end
      BEAT1: if (bus.out_ready) state_d = bus.in_valid ? BEAT0 : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Ready reopens combinationally when the last beat of the current group is taken.
  always_comb begin
    in_ready  = (state_q == EMPTY) | (valid_q & bus.out_ready & last_q);
    accept    = bus.in_valid & in_ready;
    load_pend = (state_q == BEAT0) & bus.out_ready & ~last_q;
    drain     = valid_q & bus.out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      off_q      <= '0;
      pend_col_q <= '0;
      pend_off_q <= '0;
      sign_q     <= '0;
      act_q      <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
    end else if (accept) begin
      col_q      <= b0_col;
      off_q      <= b0_off;
      pend_col_q <= b1_col;
      pend_off_q <= b1_off;
      for (int unsigned i = 0; i < NW; i++) sign_q[i] <= bus.weights[8*i+7];
      act_q      <= bus.in_activations;
      valid_q    <= 1'b1;
      first_q    <= 1'b1;
      last_q     <= ~two_beats;
    end else if (load_pend) begin
      col_q   <= pend_col_q;
      off_q   <= pend_off_q;
      first_q <= 1'b0;
      last_q  <= 1'b1;
    end else if (drain) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = valid_q;
  assign bus.weight_column0 = col_q[0];
  assign bus.weight_column1 = col_q[1];
  assign bus.weight_column2 = col_q[2];
  assign bus.weight_column3 = col_q[3];
  assign bus.shift_offset   = off_q;
  assign bus.weight_sign    = sign_q;
  assign bus.activations    = act_q;
  assign bus.out_first      = first_q;
  assign bus.out_last       = last_q;
endmodule

// File: tb/tb_bcol_scheduler.sv
// Bench for bcol_scheduler: directed groups plus random traffic against a
// queue-of-beats reference model built from the column-skipping rules.
module tb_bcol_scheduler;
  typedef struct packed {
    logic [31:0] cols;
    logic [11:0] off;
    logic [7:0]  sign;
    logic [63:0] act;
    logic        first;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bcol_if bus();

  bcol_scheduler dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  beat_t q[$];
  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Expected beats of one group, from magnitudes and the list of non-zero columns.
  task automatic model_push(input logic [63:0] w, input logic [63:0] a);
    int mag[8];
    logic [7:0] colv[7];
    int ks[$];
    int nb;
    logic [7:0] sgn;
    beat_t b;
    for (int i = 0; i < 8; i++) begin
      int v;
      v = $signed(w[8*i +: 8]);
      mag[i] = (v < 0) ? -v : v;
      if (mag[i] > 127) mag[i] = 127;
      sgn[i] = (v < 0);
    end
    for (int k = 0; k < 7; k++) begin
      colv[k] = '0;
      for (int i = 0; i < 8; i++) colv[k][i] = ((mag[i] >> k) & 1) != 0;
      if (colv[k] != 8'h00) ks.push_back(k);
    end
    nb = (ks.size() > 4) ? 2 : 1;
    for (int bi = 0; bi < nb; bi++) begin
      b = '0;
      for (int j = 0; j < 4; j++) begin
        int idx;
        idx = bi * 4 + j;
        if (idx < ks.size()) begin
          b.cols[8*j +: 8] = colv[ks[idx]];
          b.off[3*j +: 3]  = 3'(ks[idx]);
        end
      end
      b.sign  = sgn;
      b.act   = a;
      b.first = (bi == 0);
      b.last  = (bi == nb - 1);
      q.push_back(b);
    end
  endtask

  // One cycle: drive at the falling edge, check settled outputs, advance the model.
  task automatic step(input bit iv, input logic [63:0] w, input logic [63:0] a, input bit ordy);
    bit exp_ir;
    beat_t h;
    @(negedge clk);
    bus.in_valid       = iv;
    bus.weights        = w;
    bus.in_activations = a;
    bus.out_ready      = ordy;
    #1;
    exp_ir = (q.size() == 0) || (q.size() == 1 && ordy);
    chk("in_ready", 64'(bus.in_ready), 64'(exp_ir));
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      h = q[0];
      chk("col0", 64'(bus.weight_column0), 64'(h.cols[7:0]));
      chk("col1", 64'(bus.weight_column1), 64'(h.cols[15:8]));
      chk("col2", 64'(bus.weight_column2), 64'(h.cols[23:16]));
      chk("col3", 64'(bus.weight_column3), 64'(h.cols[31:24]));
      chk("shift_offset", 64'(bus.shift_offset), 64'(h.off));
      chk("weight_sign", 64'(bus.weight_sign), 64'(h.sign));
      chk("activations", bus.activations, h.act);
      chk("out_first", 64'(bus.out_first), 64'(h.first));
      chk("out_last", 64'(bus.out_last), 64'(h.last));
      if (ordy) void'(q.pop_front());
    end
    if (iv && exp_ir) model_push(w, a);
  endtask

  task automatic chk_zero(input string ph);
    chk({ph, "_valid"}, 64'(bus.out_valid), 64'(0));
    chk({ph, "_first"}, 64'(bus.out_first), 64'(0));
    chk({ph, "_last"}, 64'(bus.out_last), 64'(0));
    chk({ph, "_cols"}, {bus.weight_column3, bus.weight_column2, bus.weight_column1, bus.weight_column0}, 64'(0));
    chk({ph, "_off"}, 64'(bus.shift_offset), 64'(0));
    chk({ph, "_sign"}, 64'(bus.weight_sign), 64'(0));
    chk({ph, "_act"}, bus.activations, 64'(0));
    chk({ph, "_in_ready"}, 64'(bus.in_ready), 64'(1));
  endtask

  function automatic logic [63:0] rand_w();
    logic [63:0] r;
    logic [6:0] m;
    m = 7'($urandom_range(0, 127));
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = 8'($urandom) & {1'b1, m};
      if ($urandom_range(0, 15) == 0) r[8*i +: 8] = 8'h80;
    end
    return r;
  endfunction

  initial begin
    bus.in_valid       = 1'b0;
    bus.weights        = '0;
    bus.in_activations = '0;
    bus.out_ready      = 1'b0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // single beat, then two beats, then sign/saturation, then all-zero
    step(1, {8{8'h01}}, 64'h0123_4567_89AB_CDEF, 1);
    step(0, '0, '0, 1);
    step(1, {8{8'h7F}}, 64'h1111_2222_3333_4444, 1);
    step(0, '0, '0, 1);
    step(0, '0, '0, 1);
    step(1, {{7{8'hFD}}, 8'h80}, 64'hDEAD_BEEF_0000_0001, 1);
    step(0, '0, '0, 1);
    step(0, '0, '0, 1);
    step(1, 64'h0, 64'hFFFF_0000_FFFF_0000, 1);
    step(0, '0, '0, 1);

    // backpressure hold, then three back-to-back single-beat groups
    step(1, {8{8'h03}}, 64'hAAAA_0000_0000_0001, 0);
    repeat (5) step(1, {8{8'h05}}, 64'hAAAA_0000_0000_0002, 0);
    step(1, {8{8'h05}}, 64'hAAAA_0000_0000_0002, 1);
    step(1, {8{8'h09}}, 64'hAAAA_0000_0000_0003, 1);
    step(1, {8{8'h0C}}, 64'hAAAA_0000_0000_0004, 1);
    step(0, '0, '0, 1);
    step(0, '0, '0, 1);

    // reset during beat 0 of a two-beat group
    step(1, {8{8'h7F}}, 64'h5555_6666_7777_8888, 0);
    step(0, '0, '0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) step(0, '0, '0, 1);

    // random traffic with random backpressure
    repeat (400) step(1'($urandom_range(0, 1)), rand_w(), {$urandom, $urandom},
                      $urandom_range(0, 3) != 0);
    repeat (4) step(0, '0, '0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
